// File: rtl/cga_palette_pkg.sv
//==============================================================================
// Module : cga_palette_pkg
// Brief  : Shared constants, types and CGA default-colour helpers for the
//          programmable palette DAC.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package cga_palette_pkg;

    localparam logic [1:0] ADDR_WIDX = 2'd0;
    localparam logic [1:0] ADDR_DATA = 2'd1;
    localparam logic [1:0] ADDR_RIDX = 2'd2;
    localparam logic [1:0] ADDR_MASK = 2'd3;

    typedef enum logic [1:0] {
        PH_R = 2'd0,
        PH_G = 2'd1,
        PH_B = 2'd2
    } phase_t;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Per-colour {R,G,B} levels, 2 bits each; entry 6 is brown (G at level 1).
    localparam logic [15:0][5:0] CGA_LEVELS = {
        6'b11_11_11,    // 15
        6'b11_11_01,    // 14
        6'b11_01_11,    // 13
        6'b11_01_01,    // 12
        6'b01_11_11,    // 11
        6'b01_11_01,    // 10
        6'b01_01_11,    // 9
        6'b01_01_01,    // 8
        6'b10_10_10,    // 7
        6'b10_01_00,    // 6
        6'b10_00_10,    // 5
        6'b10_00_00,    // 4
        6'b00_10_10,    // 3
        6'b00_10_00,    // 2
        6'b00_00_10,    // 1
        6'b00_00_00     // 0
    };

    // Level l maps to l*(2^ch_w-1)/3, exact for even channel widths.
    function automatic logic [7:0] level_value(input logic [1:0] lvl, input int ch_w);
        int full;
        full = (1 << ch_w) - 1;
        return 8'((int'(lvl) * full) / 3);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cga_palette_dac_palette_ram.sv
//==============================================================================
// Module : palette_ram
// Brief  : Palette storage, one write port and two synchronous read ports
//          (pixel, host) with read-before-write behaviour.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module palette_ram #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 18
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] pix_addr,
    output logic [DATA_W-1:0] pix_data,
    input  logic [ADDR_W-1:0] host_addr,
    output logic [DATA_W-1:0] host_data
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    // Reads see the pre-write contents when addresses collide.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
        pix_data  <= r_mem[pix_addr];
        host_data <= r_mem[host_addr];
    end

endmodule

`default_nettype wire

// File: rtl/cga_palette_dac.sv
//==============================================================================
// Module : cga_palette_dac
// Brief  : Programmable palette DAC with VGA-DAC style host registers and
//          CGA default colours loaded after reset.
// Option : PALETTE_PIXEL_MASK_EN adds the pixel mask register at address 3.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module cga_palette_dac
    import cga_palette_pkg::*;
#(
    parameter int IDX_W = 4,
    parameter int CH_W  = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] video,
    input  logic             blank,
    output logic [CH_W-1:0]  red,
    output logic [CH_W-1:0]  green,
    output logic [CH_W-1:0]  blue,
    input  logic [1:0]       bus_addr,
    input  logic             bus_we,
    input  logic             bus_re,
    input  logic [7:0]       bus_wdata,
    output logic [7:0]       bus_rdata,
    output logic             bus_rvalid,
    output logic             busy
);

    localparam int c_DATA_W = 3 * CH_W;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [IDX_W-1:0]    r_init_cnt;

    logic [IDX_W-1:0]    r_wr_idx;
    logic [IDX_W-1:0]    r_rd_idx;
    phase_t              r_wr_phase;
    phase_t              r_rd_phase;
    logic [CH_W-1:0]     r_hold_r;
    logic [CH_W-1:0]     r_hold_g;

    logic                w_ram_we;
    logic [IDX_W-1:0]    w_ram_waddr;
    logic [c_DATA_W-1:0] w_ram_wdata;
    logic [c_DATA_W-1:0] w_pix_data;
    logic [c_DATA_W-1:0] w_host_data;
    logic [IDX_W-1:0]    w_pix_idx;

    logic [5:0]          w_def_lvl;
    logic [c_DATA_W-1:0] w_def_rgb;

    logic                w_run;
    logic                w_rd_fire;
    logic [7:0]          w_reg_rdata;
    logic [CH_W-1:0]     w_host_chan;

    logic                r_h1_valid;
    logic                r_h1_zero;
    logic [1:0]          r_h1_addr;
    phase_t              r_h1_phase;
    logic [7:0]          r_h1_reg;
    logic                r_blank1;

    logic                w_unused_bits;

    assign w_unused_bits = ^bus_wdata;
    assign w_run         = (r_state == ST_RUN);
    assign busy          = (r_state == ST_INIT);
    assign w_rd_fire     = bus_re && !bus_we;

`ifdef PALETTE_PIXEL_MASK_EN
    logic [IDX_W-1:0] r_mask;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mask <= '1;
        end else if (w_run && bus_we && bus_addr == ADDR_MASK) begin
            r_mask <= bus_wdata[IDX_W-1:0];
        end
    end

    assign w_pix_idx = video & r_mask;
`else
    assign w_pix_idx = video;
`endif

    // ---------------- state machine ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_INIT) begin
                r_init_cnt <= r_init_cnt + 1'b1;
            end
        end
    end

    assign w_def_lvl = CGA_LEVELS[r_init_cnt[3:0]];
    assign w_def_rgb = {CH_W'(level_value(w_def_lvl[5:4], CH_W)),
                        CH_W'(level_value(w_def_lvl[3:2], CH_W)),
                        CH_W'(level_value(w_def_lvl[1:0], CH_W))};

    always_comb begin
        w_state_nxt = r_state;
        w_ram_we    = 1'b0;
        w_ram_waddr = r_wr_idx;
        w_ram_wdata = {r_hold_r, r_hold_g, bus_wdata[CH_W-1:0]};
        case (r_state)
            ST_INIT: begin
                w_ram_we    = 1'b1;
                w_ram_waddr = r_init_cnt;
                w_ram_wdata = w_def_rgb;
                if (r_init_cnt == {IDX_W{1'b1}}) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_ram_we = bus_we && (bus_addr == ADDR_DATA) && (r_wr_phase == PH_B);
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    // ---------------- host register file ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_idx   <= '0;
            r_rd_idx   <= '0;
            r_wr_phase <= PH_R;
            r_rd_phase <= PH_R;
            r_hold_r   <= '0;
            r_hold_g   <= '0;
        end else if (w_run) begin
            if (bus_we) begin
                case (bus_addr)
                    ADDR_WIDX: begin
                        r_wr_idx   <= bus_wdata[IDX_W-1:0];
                        r_wr_phase <= PH_R;
                    end
                    ADDR_DATA: begin
                        case (r_wr_phase)
                            PH_R: begin
                                r_hold_r   <= bus_wdata[CH_W-1:0];
                                r_wr_phase <= PH_G;
                            end
                            PH_G: begin
                                r_hold_g   <= bus_wdata[CH_W-1:0];
                                r_wr_phase <= PH_B;
                            end
                            default: begin
                                r_wr_idx   <= r_wr_idx + 1'b1;
                                r_wr_phase <= PH_R;
                            end
                        endcase
                    end
                    ADDR_RIDX: begin
                        r_rd_idx   <= bus_wdata[IDX_W-1:0];
                        r_rd_phase <= PH_R;
                    end
                    default: ;
                endcase
            end else if (bus_re && bus_addr == ADDR_DATA) begin
                case (r_rd_phase)
                    PH_R:    r_rd_phase <= PH_G;
                    PH_G:    r_rd_phase <= PH_B;
                    default: begin
                        r_rd_idx   <= r_rd_idx + 1'b1;
                        r_rd_phase <= PH_R;
                    end
                endcase
            end
        end
    end

    always_comb begin
        w_reg_rdata = 8'h00;
        case (bus_addr)
            ADDR_WIDX: w_reg_rdata = 8'(r_wr_idx);
            ADDR_RIDX: w_reg_rdata = 8'(r_rd_idx);
`ifdef PALETTE_PIXEL_MASK_EN
            ADDR_MASK: w_reg_rdata = 8'(r_mask);
`else
            ADDR_MASK: w_reg_rdata = 8'hFF;
`endif
            default:   w_reg_rdata = 8'h00;
        endcase
    end

    palette_ram #(
        .ADDR_W (IDX_W),
        .DATA_W (c_DATA_W)
    ) u_ram (
        .clk       (clk),
        .we        (w_ram_we),
        .waddr     (w_ram_waddr),
        .wdata     (w_ram_wdata),
        .pix_addr  (w_pix_idx),
        .pix_data  (w_pix_data),
        .host_addr (r_rd_idx),
        .host_data (w_host_data)
    );

    // ---------------- host read pipeline ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_h1_valid <= 1'b0;
            r_h1_zero  <= 1'b0;
            r_h1_addr  <= ADDR_WIDX;
            r_h1_phase <= PH_R;
            r_h1_reg   <= 8'h00;
        end else begin
            r_h1_valid <= w_rd_fire;
            r_h1_zero  <= !w_run;
            r_h1_addr  <= bus_addr;
            r_h1_phase <= r_rd_phase;
            r_h1_reg   <= w_reg_rdata;
        end
    end

    always_comb begin
        w_host_chan = w_host_data[CH_W-1:0];
        case (r_h1_phase)
            PH_R:    w_host_chan = w_host_data[3*CH_W-1:2*CH_W];
            PH_G:    w_host_chan = w_host_data[2*CH_W-1:CH_W];
            default: w_host_chan = w_host_data[CH_W-1:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus_rdata  <= 8'h00;
            bus_rvalid <= 1'b0;
        end else begin
            bus_rvalid <= r_h1_valid;
            if (r_h1_valid) begin
                if (r_h1_zero) begin
                    bus_rdata <= 8'h00;
                end else if (r_h1_addr == ADDR_DATA) begin
                    bus_rdata <= 8'(w_host_chan);
                end else begin
                    bus_rdata <= r_h1_reg;
                end
            end
        end
    end

    // ---------------- pixel path ----------------
    // Blank is forced during initialisation so partly loaded palettes never show.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_blank1 <= 1'b1;
            red      <= '0;
            green    <= '0;
            blue     <= '0;
        end else begin
            r_blank1 <= blank || !w_run;
            if (r_blank1) begin
                red   <= '0;
                green <= '0;
                blue  <= '0;
            end else begin
                red   <= w_pix_data[3*CH_W-1:2*CH_W];
                green <= w_pix_data[2*CH_W-1:CH_W];
                blue  <= w_pix_data[CH_W-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cga_palette_dac.sv
//==============================================================================
// Module : tb_cga_palette_dac
// Brief  : Directed bench for cga_palette_dac with queued expectations.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_cga_palette_dac;

    localparam int IDX_W = 4;
    localparam int CH_W  = 6;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [IDX_W-1:0] video;
    logic             blank;
    logic [CH_W-1:0]  red, green, blue;
    logic [1:0]       bus_addr;
    logic             bus_we, bus_re;
    logic [7:0]       bus_wdata;
    logic [7:0]       bus_rdata;
    logic             bus_rvalid;
    logic             busy;

    int checks = 0;
    int errors = 0;

    logic [17:0] pix_q[$];
    string       pix_n[$];
    logic [7:0]  rd_q[$];
    string       rd_n[$];

    logic        pix_req = 1'b0;
    logic [1:0]  pix_pipe = 2'b00;
    logic [17:0] pexp;
    logic [7:0]  rexp;
    string       cname;

    always #5 clk = ~clk;

    cga_palette_dac #(.IDX_W(IDX_W), .CH_W(CH_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .video      (video),
        .blank      (blank),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .bus_addr   (bus_addr),
        .bus_we     (bus_we),
        .bus_re     (bus_re),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_rvalid (bus_rvalid),
        .busy       (busy)
    );

    function automatic logic [17:0] rgb(input logic [5:0] r, input logic [5:0] g, input logic [5:0] b);
        return {r, g, b};
    endfunction

    // Monitor: pixel results land two edges after issue, host reads when rvalid pulses.
    always @(posedge clk) pix_pipe <= {pix_pipe[0], pix_req};

    always @(negedge clk) begin
        if (pix_pipe[1]) begin
            checks++;
            if (pix_q.size() == 0) begin
                errors++;
                $display("FAIL pixel_unexpected: got %h/%h/%h with empty queue", red, green, blue);
            end else begin
                pexp  = pix_q.pop_front();
                cname = pix_n.pop_front();
                if ({red, green, blue} !== pexp) begin
                    errors++;
                    $display("FAIL %s: got %h/%h/%h expected %h/%h/%h", cname, red, green, blue,
                             pexp[17:12], pexp[11:6], pexp[5:0]);
                end
            end
        end
        if (bus_rvalid === 1'b1) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL rvalid_unexpected: got rdata %h with no read pending", bus_rdata);
            end else begin
                rexp  = rd_q.pop_front();
                cname = rd_n.pop_front();
                if (bus_rdata !== rexp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", cname, bus_rdata, rexp);
                end
            end
        end
    end

    task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, got, exp);
        end
    endtask

    task automatic pix(input logic [3:0] v, input logic b, input logic [17:0] e, input string n);
        video   = v;
        blank   = b;
        pix_req = 1'b1;
        pix_q.push_back(e);
        pix_n.push_back(n);
        @(negedge clk);
        pix_req = 1'b0;
        blank   = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        bus_addr  = a;
        bus_wdata = d;
        bus_we    = 1'b1;
        @(negedge clk);
        bus_we    = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [7:0] e, input string n);
        bus_addr = a;
        bus_re   = 1'b1;
        rd_q.push_back(e);
        rd_n.push_back(n);
        @(negedge clk);
        bus_re   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ready(input string n, input int exp_cycles);
        int cyc;
        cyc = 0;
        while (busy && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check(n, 32'(cyc), 32'(exp_cycles));
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; video = '0; blank = 1'b0;
        bus_addr = 2'd0; bus_we = 1'b0; bus_re = 1'b0; bus_wdata = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_busy",   32'(busy), 32'd1);
        check("reset_rgb",    32'({red, green, blue}), 32'd0);
        check("reset_rvalid", 32'(bus_rvalid), 32'd0);
        check("reset_rdata",  32'(bus_rdata), 32'd0);

        rst_n = 1'b1;
        wait_ready("init_cycles", 16);

        pix(4'd6,  1'b0, rgb(6'h2A, 6'h15, 6'h00), "default_6_brown");
        pix(4'd9,  1'b0, rgb(6'h15, 6'h15, 6'h3F), "default_9");
        pix(4'd15, 1'b0, rgb(6'h3F, 6'h3F, 6'h3F), "default_15");
        pix(4'd0,  1'b0, rgb(6'h00, 6'h00, 6'h00), "default_0");
        rd(2'd0, 8'h00, "widx_reset");
        rd(2'd2, 8'h00, "ridx_reset");

        wr(2'd0, 8'h05);
        wr(2'd1, 8'h3F); wr(2'd1, 8'h00); wr(2'd1, 8'h3F);
        pix(4'd5, 1'b0, rgb(6'h3F, 6'h00, 6'h3F), "write_entry5");
        rd(2'd0, 8'h06, "widx_after_commit");

        wr(2'd0, 8'h0F);
        wr(2'd1, 8'h01); wr(2'd1, 8'h02); wr(2'd1, 8'h03);
        wr(2'd1, 8'h04); wr(2'd1, 8'h05); wr(2'd1, 8'h06);
        pix(4'd15, 1'b0, rgb(6'h01, 6'h02, 6'h03), "wrap_entry15");
        pix(4'd0,  1'b0, rgb(6'h04, 6'h05, 6'h06), "wrap_entry0");
        rd(2'd0, 8'h01, "widx_wrapped");

        wr(2'd2, 8'h09);
        rd(2'd1, 8'h15, "rdata_9_r");
        rd(2'd1, 8'h15, "rdata_9_g");
        rd(2'd1, 8'h3F, "rdata_9_b");
        rd(2'd2, 8'h0A, "ridx_advanced");

        wr(2'd0, 8'h03);
        wr(2'd1, 8'h11); wr(2'd1, 8'h22);
        wr(2'd0, 8'h03);
        pix(4'd3, 1'b0, rgb(6'h00, 6'h2A, 6'h2A), "partial_not_committed");
        wr(2'd1, 8'h07); wr(2'd1, 8'h08); wr(2'd1, 8'h09);
        pix(4'd3, 1'b0, rgb(6'h07, 6'h08, 6'h09), "phase_restart");
        wr(2'd2, 8'h03);
        rd(2'd1, 8'h07, "readback_3_r");
        rd(2'd1, 8'h08, "readback_3_g");
        rd(2'd1, 8'h09, "readback_3_b");

        // Simultaneous strobes: the write lands and no read response appears.
        bus_addr = 2'd0; bus_wdata = 8'h07; bus_we = 1'b1; bus_re = 1'b1;
        @(negedge clk);
        bus_we = 1'b0; bus_re = 1'b0;
        idle(3);
        rd(2'd0, 8'h07, "we_wins_over_re");

`ifdef PALETTE_PIXEL_MASK_EN
        wr(2'd3, 8'h03);
        rd(2'd3, 8'h03, "mask_readback");
        pix(4'hE, 1'b0, rgb(6'h00, 6'h2A, 6'h00), "masked_pixel");
`else
        wr(2'd3, 8'h03);
        rd(2'd3, 8'hFF, "mask_absent_read");
        pix(4'hE, 1'b0, rgb(6'h3F, 6'h3F, 6'h15), "unmasked_pixel");
`endif
        pix(4'd15, 1'b1, rgb(6'h00, 6'h00, 6'h00), "blank_forces_black");
        pix(4'd9,  1'b0, rgb(6'h15, 6'h15, 6'h3F), "after_blank");

        idle(4);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_pulse_busy", 32'(busy), 32'd1);
        rd(2'd0, 8'h00, "init_read_zero");
        wr(2'd0, 8'h09);
        wait_ready("reinit_cycles", 14);
        rd(2'd0, 8'h00, "init_write_ignored");
        pix(4'd2,  1'b0, rgb(6'h00, 6'h2A, 6'h00), "restored_entry2");
        pix(4'd5,  1'b0, rgb(6'h2A, 6'h00, 6'h2A), "restored_entry5");
        pix(4'd15, 1'b0, rgb(6'h3F, 6'h3F, 6'h3F), "restored_entry15");
        pix(4'hE,  1'b0, rgb(6'h3F, 6'h3F, 6'h15), "entry14_after_reset");

        idle(4);
        check("pixel_queue_drained", 32'(pix_q.size()), 32'd0);
        check("read_queue_drained",  32'(rd_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

endmodule

`default_nettype wire
